solver_sequencer: RTL and testbench
===================================

SOLVER_SEQUENCER -- requirements
Module: solver_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: request FIFO entries, power of two, minimum 2.
REQ-002 Parameter WALK_MAX, default 1024: maximum consecutive WALK cycles per WALK request, 1..65535.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid/req_ready  in/out  1/1  host request handshake; transfer when both high on a clk edge.
REQ-006 req_op, req_a, req_b, req_c  in  8 each  opcode and three operand bytes.
REQ-007 rsp_valid  out  1  one-cycle response pulse; no backpressure.
REQ-008 rsp_kind  out  2  0=STATE_BYTE, 1=SAT, 2=UNSAT, 3=TIMEOUT.
REQ-009 rsp_data  out  8  exbus byte for STATE_BYTE, else 0.
REQ-010 busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.
REQ-011 sol_cmd, sol_bus_a, sol_bus_b, sol_bus_c  out  8 each  registered drive to solver cmd/bus ports.
REQ-012 sol_sat, sol_unsat, sol_exbus  in  1/1/8  solver status and readback.

Function
REQ-013 Opcodes SHALL be RST_MODEL=0, RST_STATE=1, INS_CLAUSE=2, GET_STATE=3, WALK=4; sol_cmd SHALL be IDLE_CMD=8'hFF in every cycle no opcode is issued.
REQ-014 req_ready SHALL be high exactly when the FIFO is not full; a push and a pop in the same cycle are allowed when the FIFO is full, and the pop frees the slot for the following cycle only.
REQ-015 FSM states: IDLE, ISSUE, READ1, READ2, WALK, RESP.
REQ-016 IDLE with the FIFO non-empty: pop the head and go to ISSUE; sol_cmd and the operands SHALL show the popped entry in the next cycle.
REQ-017 ISSUE drives one cycle of opcode 0, 1 or 2 with operands, then returns to IDLE: back-to-back entries issue every 2 cycles.
REQ-018 GET_STATE: ISSUE drives cmd=3 for 1 cycle (cycle N), READ1 waits (N+1), READ2 samples sol_exbus at the end of N+1; rsp_valid=1, kind=0 in N+2.
REQ-019 WALK: cmd=4 is held every cycle with a 16-bit cycle counter starting at 1; each cycle sample sol_sat/sol_unsat; on either high go to RESP with kind SAT or UNSAT; if both are high, SAT wins.
REQ-020 WALK: if the counter reaches WALK_MAX with neither flag high, go to RESP with kind TIMEOUT; sol_cmd returns to IDLE_CMD in the RESP cycle.
REQ-021 RESP asserts rsp_valid for exactly 1 cycle, then goes to IDLE.
REQ-022 Opcodes >4 SHALL be popped and discarded in IDLE with no solver command and no response, costing 1 cycle.
REQ-023 sol_bus_* SHALL hold the last issued operands while sol_cmd=IDLE_CMD.

Reset
REQ-024 rst high: the FIFO empties, the FSM goes to IDLE, sol_cmd=8'hFF, sol_bus_* = 0, rsp_valid=0, rsp_kind=0, rsp_data=0, busy=0, req_ready=0 while rst is asserted, and the counter clears; any in-flight WALK or GET_STATE is abandoned with no response.
REQ-025 req_ready SHALL rise in the first cycle after rst deasserts.

Configuration
REQ-026 Macro SOLVER_SEQ_STATS_EN defined: add output walk_cycles[31:0], a saturating count of all cycles with sol_cmd=4 since reset.
REQ-027 Macro SOLVER_SEQ_STATS_EN undefined: the walk_cycles port and counter are absent; all other behaviour is identical.

Structure
REQ-028 Package solver_pkg SHALL hold the opcode constants, IDLE_CMD, the rsp_kind enum and the FSM state enum, shared with the solver.
REQ-029 The request FIFO SHALL be sub-module seq_fifo (32-bit entries, parameter FIFO_DEPTH, full/empty flags).

Verification
REQ-030 Push INS_CLAUSE(a=3, b=5, c=7) in IDLE -> sol_cmd=2, bus=3/5/7 for exactly 1 cycle, 1 cycle after the pop; no rsp.
REQ-031 GET_STATE with sol_exbus=8'hA5 -> rsp_valid with kind=0, data=A5 exactly 2 cycles after cmd=3.
REQ-032 WALK, sol_sat raised on the 10th WALK cycle -> rsp kind=1 the next cycle; 10 cmd=4 cycles total; sat and unsat both high -> kind=1.
REQ-033 WALK, WALK_MAX=8, flags never set -> exactly 8 cmd=4 cycles, then kind=3.
REQ-034 Push 6 requests without a gap, FIFO_DEPTH=4 -> req_ready low once full, no loss, in-order issue; opcode 9 is dropped silently.
REQ-035 Assert rst mid-WALK -> sol_cmd=FF, busy=0, no rsp; the next request runs normally.

Source files
------------

// File: rtl/solver_pkg.sv
// Shared definitions for the solver sequencer and the solver it drives:
// opcodes, the idle command byte, response kinds and sequencer FSM states.
package solver_pkg;

    localparam logic [7:0] OP_RST_MODEL  = 8'd0;
    localparam logic [7:0] OP_RST_STATE  = 8'd1;
    localparam logic [7:0] OP_INS_CLAUSE = 8'd2;
    localparam logic [7:0] OP_GET_STATE  = 8'd3;
    localparam logic [7:0] OP_WALK       = 8'd4;
    localparam logic [7:0] IDLE_CMD      = 8'hFF;

    typedef enum logic [1:0] {
        RSP_STATE_BYTE = 2'd0,
        RSP_SAT        = 2'd1,
        RSP_UNSAT      = 2'd2,
        RSP_TIMEOUT    = 2'd3
    } rsp_kind_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_READ1,
        S_READ2,
        S_WALK,
        S_RESP
    } state_e;

endpackage

// File: rtl/seq_fifo.sv
// Request FIFO for the solver sequencer: 32-bit entries {op, a, b, c}.
// Pointers carry one extra wrap bit to tell full from empty. A push while
// full is ignored; a pop while empty is ignored.
module seq_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] pop_data,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [31:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/solver_sequencer.sv
// Solver sequencer: queues host requests and drives them onto the solver
// command/operand bus, returning STATE_BYTE / SAT / UNSAT / TIMEOUT responses.
// Optional feature: define SOLVER_SEQ_STATS_EN to add walk_cycles, a
// saturating count of cycles with sol_cmd = WALK since reset.
module solver_sequencer
    import solver_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WALK_MAX   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_op,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    input  logic [7:0]  req_c,
    output logic        rsp_valid,
    output logic [1:0]  rsp_kind,
    output logic [7:0]  rsp_data,
    output logic        busy,
    output logic [7:0]  sol_cmd,
    output logic [7:0]  sol_bus_a,
    output logic [7:0]  sol_bus_b,
    output logic [7:0]  sol_bus_c,
    input  logic        sol_sat,
    input  logic        sol_unsat,
    input  logic [7:0]  sol_exbus
`ifdef SOLVER_SEQ_STATS_EN
    ,
    output logic [31:0] walk_cycles
`endif
);

    localparam logic [15:0] WALK_LIMIT = 16'(WALK_MAX);

    state_e      state_q, state_n;
    logic [7:0]  op_q, op_n;
    logic [15:0] walk_cnt, walk_cnt_n;
    logic [7:0]  cmd_n, bus_a_n, bus_b_n, bus_c_n;
    logic        rsp_valid_n;
    rsp_kind_e   rsp_kind_q, rsp_kind_n;
    logic [7:0]  rsp_data_n;

    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0] head;
    logic [7:0]  head_op;

    // Ready depends only on registered FIFO state, so a pop while full
    // frees the slot for the following cycle.
    assign req_ready = !fifo_full && !rst;
    assign fifo_push = req_valid && req_ready;
    assign head_op   = head[31:24];
    assign busy      = !fifo_empty || (state_q != S_IDLE);
    assign rsp_kind  = rsp_kind_q;

    seq_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({req_op, req_a, req_b, req_c}),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state and next registered solver/response drive.
    always_comb begin
        state_n     = state_q;
        op_n        = op_q;
        walk_cnt_n  = walk_cnt;
        cmd_n       = IDLE_CMD;
        bus_a_n     = sol_bus_a;
        bus_b_n     = sol_bus_b;
        bus_c_n     = sol_bus_c;
        rsp_valid_n = 1'b0;
        rsp_kind_n  = RSP_STATE_BYTE;
        rsp_data_n  = 8'd0;
        fifo_pop    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    // Unknown opcodes are dropped here without touching the bus.
                    if (head_op <= OP_WALK) begin
                        op_n    = head_op;
                        cmd_n   = head_op;
                        bus_a_n = head[23:16];
                        bus_b_n = head[15:8];
                        bus_c_n = head[7:0];
                        if (head_op == OP_WALK) begin
                            state_n    = S_WALK;
                            walk_cnt_n = 16'd1;
                        end else begin
                            state_n = S_ISSUE;
                        end
                    end
                end
            end
            S_ISSUE: begin
                state_n = (op_q == OP_GET_STATE) ? S_READ1 : S_IDLE;
            end
            S_READ1: begin
                // Readback is valid one cycle after the GET_STATE command.
                state_n     = S_READ2;
                rsp_valid_n = 1'b1;
                rsp_kind_n  = RSP_STATE_BYTE;
                rsp_data_n  = sol_exbus;
            end
            S_READ2: begin
                state_n = S_IDLE;
            end
            S_WALK: begin
                if (sol_sat) begin
                    state_n     = S_RESP;
                    rsp_valid_n = 1'b1;
                    rsp_kind_n  = RSP_SAT;
                end else if (sol_unsat) begin
                    state_n     = S_RESP;
                    rsp_valid_n = 1'b1;
                    rsp_kind_n  = RSP_UNSAT;
                end else if (walk_cnt == WALK_LIMIT) begin
                    state_n     = S_RESP;
                    rsp_valid_n = 1'b1;
                    rsp_kind_n  = RSP_TIMEOUT;
                end else begin
                    walk_cnt_n = walk_cnt + 16'd1;
                    cmd_n      = OP_WALK;
                end
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State, solver drive and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= 8'd0;
            walk_cnt   <= 16'd0;
            sol_cmd    <= IDLE_CMD;
            sol_bus_a  <= 8'd0;
            sol_bus_b  <= 8'd0;
            sol_bus_c  <= 8'd0;
            rsp_valid  <= 1'b0;
            rsp_kind_q <= RSP_STATE_BYTE;
            rsp_data   <= 8'd0;
        end else begin
            state_q    <= state_n;
            op_q       <= op_n;
            walk_cnt   <= walk_cnt_n;
            sol_cmd    <= cmd_n;
            sol_bus_a  <= bus_a_n;
            sol_bus_b  <= bus_b_n;
            sol_bus_c  <= bus_c_n;
            rsp_valid  <= rsp_valid_n;
            rsp_kind_q <= rsp_kind_n;
            rsp_data   <= rsp_data_n;
        end
    end

`ifdef SOLVER_SEQ_STATS_EN
    // Saturating count of cycles spent driving WALK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            walk_cycles <= 32'd0;
        end else if ((sol_cmd == OP_WALK) && (walk_cycles != 32'hFFFF_FFFF)) begin
            walk_cycles <= walk_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_solver_sequencer.sv
// Directed bench for solver_sequencer with command and response scoreboards.
module tb_solver_sequencer;

    logic       clk;
    logic       rst;
    logic       req_valid, req_valid8;
    logic [7:0] req_op, req_a, req_b, req_c;
    logic       sol_sat, sol_unsat, sol_sat8, sol_unsat8;
    logic [7:0] sol_exbus;

    logic       req_ready, rsp_valid, busy;
    logic [1:0] rsp_kind;
    logic [7:0] rsp_data, sol_cmd, sol_bus_a, sol_bus_b, sol_bus_c;

    logic       req_ready8, rsp_valid8, busy8;
    logic [1:0] rsp_kind8;
    logic [7:0] rsp_data8, sol_cmd8, sol_bus_a8, sol_bus_b8, sol_bus_c8;

`ifdef SOLVER_SEQ_STATS_EN
    logic [31:0] walk_cycles, walk_cycles8;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] cmd_q [$];
    logic [31:0] rsp_q [$];
    logic [31:0] burst [6];
    bit          saw_stall;

    solver_sequencer #(.FIFO_DEPTH(4), .WALK_MAX(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .rsp_valid(rsp_valid), .rsp_kind(rsp_kind), .rsp_data(rsp_data), .busy(busy),
        .sol_cmd(sol_cmd), .sol_bus_a(sol_bus_a), .sol_bus_b(sol_bus_b), .sol_bus_c(sol_bus_c),
        .sol_sat(sol_sat), .sol_unsat(sol_unsat), .sol_exbus(sol_exbus)
`ifdef SOLVER_SEQ_STATS_EN
        , .walk_cycles(walk_cycles)
`endif
    );

    solver_sequencer #(.FIFO_DEPTH(4), .WALK_MAX(8)) dut8 (
        .clk(clk), .rst(rst), .req_valid(req_valid8), .req_ready(req_ready8),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .rsp_valid(rsp_valid8), .rsp_kind(rsp_kind8), .rsp_data(rsp_data8), .busy(busy8),
        .sol_cmd(sol_cmd8), .sol_bus_a(sol_bus_a8), .sol_bus_b(sol_bus_b8), .sol_bus_c(sol_bus_c8),
        .sol_sat(sol_sat8), .sol_unsat(sol_unsat8), .sol_exbus(sol_exbus)
`ifdef SOLVER_SEQ_STATS_EN
        , .walk_cycles(walk_cycles8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request and hold it until accepted.
    task automatic send(input bit to8, input logic [7:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] c);
        if (!to8 && op <= 8'd4) cmd_q.push_back({op, a, b, c});
        req_op = op; req_a = a; req_b = b; req_c = c;
        if (to8) req_valid8 = 1'b1; else req_valid = 1'b1;
        for (int n = 0; n < 100 && !(to8 ? req_ready8 : req_ready); n++) @(negedge clk);
        chk("send_ready", {31'd0, (to8 ? req_ready8 : req_ready)}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0; req_valid8 = 1'b0;
    endtask

    // Scoreboard monitor for the main instance.
    initial begin
        logic [7:0]  prev;
        logic [31:0] e;
        prev = 8'hFF;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 8'hFF;
            end else begin
                if (sol_cmd != 8'hFF && prev == 8'hFF) begin
                    if (cmd_q.size() == 0) begin
                        chk("cmd_unexpected", {sol_cmd, sol_bus_a, sol_bus_b, sol_bus_c}, 32'hFFFF_FFFF);
                    end else begin
                        e = cmd_q.pop_front();
                        chk("cmd_issue", {sol_cmd, sol_bus_a, sol_bus_b, sol_bus_c}, e);
                    end
                end
                prev = sol_cmd;
                if (rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
                    end else begin
                        e = rsp_q.pop_front();
                        chk("rsp_kind_data", {22'd0, rsp_kind, rsp_data}, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_valid8 = 1'b0;
        req_op = 8'd0; req_a = 8'd0; req_b = 8'd0; req_c = 8'd0;
        sol_sat = 1'b0; sol_unsat = 1'b0; sol_sat8 = 1'b0; sol_unsat8 = 1'b0;
        sol_exbus = 8'h00;
        burst[0] = {8'd4, 8'h40, 8'h41, 8'h42};
        burst[1] = {8'd2, 8'h01, 8'h02, 8'h03};
        burst[2] = {8'd1, 8'h04, 8'h05, 8'h06};
        burst[3] = {8'd9, 8'h99, 8'h99, 8'h99};
        burst[4] = {8'd2, 8'h07, 8'h08, 8'h09};
        burst[5] = {8'd0, 8'h0A, 8'h0B, 8'h0C};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd", {24'd0, sol_cmd}, 32'hFF);
        chk("rst_bus", {8'd0, sol_bus_a, sol_bus_b, sol_bus_c}, 32'd0);
        chk("rst_rsp", {21'd0, rsp_valid, rsp_kind, rsp_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // INS_CLAUSE 3/5/7: one command cycle, operands then held
        send(1'b0, 8'd2, 8'd3, 8'd5, 8'd7);
        @(negedge clk);
        chk("ins_cmd", {sol_cmd, sol_bus_a, sol_bus_b, sol_bus_c}, 32'h02030507);
        @(negedge clk);
        chk("ins_cmd_idle_hold", {sol_cmd, sol_bus_a, sol_bus_b, sol_bus_c}, 32'hFF030507);
        chk("ins_no_rsp", {31'd0, rsp_valid}, 32'd0);

        // GET_STATE: response two cycles after cmd=3
        sol_exbus = 8'hA5;
        rsp_q.push_back({22'd0, 2'd0, 8'hA5});
        send(1'b0, 8'd3, 8'h11, 8'h12, 8'h13);
        @(negedge clk);
        chk("get_cmd", {24'd0, sol_cmd}, 32'd3);
        @(negedge clk);
        chk("get_wait", {23'd0, rsp_valid, sol_cmd}, 32'h0FF);
        @(negedge clk);
        sol_exbus = 8'h3C;
        chk("get_rsp", {21'd0, rsp_valid, rsp_kind, rsp_data}, {21'd0, 1'b1, 2'd0, 8'hA5});
        @(negedge clk);
        chk("get_rsp_pulse", {31'd0, rsp_valid}, 32'd0);

        // WALK with SAT on the 10th cycle
        rsp_q.push_back({22'd0, 2'd1, 8'd0});
        send(1'b0, 8'd4, 8'h21, 8'h22, 8'h23);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk("walk_sat_cmd", {24'd0, sol_cmd}, 32'd4);
        end
        sol_sat = 1'b1;
        @(negedge clk);
        sol_sat = 1'b0;
        chk("walk_sat_rsp", {21'd0, rsp_valid, rsp_kind, sol_cmd}, {21'd0, 1'b1, 2'd1, 8'hFF});
        @(negedge clk);
        chk("walk_sat_pulse", {31'd0, rsp_valid}, 32'd0);

        // WALK with SAT and UNSAT together: SAT wins
        rsp_q.push_back({22'd0, 2'd1, 8'd0});
        send(1'b0, 8'd4, 8'h31, 8'h32, 8'h33);
        @(negedge clk);
        chk("walk_both_cmd", {24'd0, sol_cmd}, 32'd4);
        sol_sat = 1'b1; sol_unsat = 1'b1;
        @(negedge clk);
        sol_sat = 1'b0; sol_unsat = 1'b0;
        chk("walk_both_rsp", {30'd0, rsp_kind}, 32'd1);

        // WALK with UNSAT only
        @(negedge clk);
        rsp_q.push_back({22'd0, 2'd2, 8'd0});
        send(1'b0, 8'd4, 8'h34, 8'h35, 8'h36);
        @(negedge clk);
        sol_unsat = 1'b1;
        @(negedge clk);
        sol_unsat = 1'b0;
        chk("walk_unsat_rsp", {29'd0, rsp_valid, rsp_kind}, {29'd0, 1'b1, 2'd2});

        // WALK_MAX = 8 timeout on the second instance
        @(negedge clk);
        send(1'b1, 8'd4, 8'h51, 8'h52, 8'h53);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("timeout_cmd", {24'd0, sol_cmd8}, 32'd4);
        end
        @(negedge clk);
        chk("timeout_rsp", {13'd0, rsp_valid8, rsp_kind8, rsp_data8, sol_cmd8},
            {13'd0, 1'b1, 2'd3, 8'd0, 8'hFF});
        @(negedge clk);
        chk("timeout_idle", {30'd0, rsp_valid8, busy8}, 32'd0);

        // Six requests back to back into a depth-4 FIFO; opcode 9 dropped
        rsp_q.push_back({22'd0, 2'd1, 8'd0});
        saw_stall = 1'b0;
        req_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            {req_op, req_a, req_b, req_c} = burst[k];
            if (burst[k][31:24] <= 8'd4) cmd_q.push_back(burst[k]);
            for (int n = 0; n < 100 && !req_ready; n++) begin
                saw_stall = 1'b1;
                sol_sat = 1'b1;
                @(negedge clk);
            end
            chk("burst_ready", {31'd0, req_ready}, 32'd1);
            @(negedge clk);
        end
        req_valid = 1'b0;
        sol_sat = 1'b0;
        chk("burst_saw_full", {31'd0, saw_stall}, 32'd1);
        for (int n = 0; n < 200 && busy; n++) @(negedge clk);
        @(negedge clk);
        chk("burst_drained", {31'd0, busy}, 32'd0);
        chk("burst_cmd_q_empty", cmd_q.size(), 32'd0);
        chk("burst_rsp_q_empty", rsp_q.size(), 32'd0);

        // Reset in the middle of a WALK abandons it silently
        send(1'b0, 8'd4, 8'h61, 8'h62, 8'h63);
        repeat (3) @(negedge clk);
        chk("midwalk_cmd", {24'd0, sol_cmd}, 32'd4);
        rst = 1'b1;
        #1;
        chk("midwalk_rst_out", {21'd0, busy, rsp_valid, req_ready, sol_cmd}, 32'h0FF);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midwalk_ready", {30'd0, req_ready, rsp_valid}, 32'd2);
        send(1'b0, 8'd2, 8'h11, 8'h22, 8'h33);
        @(negedge clk);
        chk("post_rst_ins", {sol_cmd, sol_bus_a, sol_bus_b, sol_bus_c}, 32'h02112233);
        repeat (4) @(negedge clk);
        chk("final_cmd_q_empty", cmd_q.size(), 32'd0);
        chk("final_rsp_q_empty", rsp_q.size(), 32'd0);
        chk("final_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
